pixel_capture: RTL and testbench

- Upstream feeder for the frame buffer. Accepts a byte-serial camera stream (vsync/href/byte) synchronous to wr_clk.
- Assembles every three bytes into one DATA_WIDTH-bit RGB pixel and drives the frame buffer's write-enable/data inputs.
- Tracks pixel and line position, marks frame boundaries and flags malformed lines/frames.

---
 rtl/pixel_capture.sv | 226 ++++++++++++++++++++++
 tb/tb_pixel_capture.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_capture.sv
// Byte-serial camera capture: packs R,G,B bytes into pixels for the frame buffer write port.
// Optional build macro PIX_CAPTURE_LINE_CHECK_EN adds err_line and drops pixels beyond H_PIXELS.
module pixel_capture #(
    parameter int BYTE_WIDTH = 8,
    parameter int DATA_WIDTH = 24,
    parameter int H_PIXELS   = 8,
    parameter int V_LINES    = 4,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic                  pix_valid,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  line_cnt,
    output logic                  err_partial,
    output logic                  err_frame
`ifdef PIX_CAPTURE_LINE_CHECK_EN
    ,
    output logic                  err_line
`endif
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_LINE = 2'd1;
    localparam logic [1:0] S_CAPTURE   = 2'd2;
    localparam logic [1:0] S_END       = 2'd3;

    localparam logic [CNT_WIDTH-1:0] V_LINES_C = CNT_WIDTH'(V_LINES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    generate
        if ((DATA_WIDTH != 3 * BYTE_WIDTH) || (H_PIXELS >= (1 << CNT_WIDTH)) ||
            (V_LINES >= (1 << CNT_WIDTH))) begin : g_bad_params
            $error("pixel_capture: inconsistent width parameters");
        end
    endgenerate

    logic [1:0]            state_q, state_d;
    logic                  vsync_q;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [BYTE_WIDTH-1:0] r_q, r_d;
    logic [BYTE_WIDTH-1:0] g_q, g_d;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_done_q, frame_done_d;
    logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
    logic                  first_q, first_d;
    logic                  err_partial_q, err_partial_d;
    logic                  err_frame_q, err_frame_d;
`ifdef PIX_CAPTURE_LINE_CHECK_EN
    logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
    logic                  err_line_q, err_line_d;
`endif

    logic vs_fall, vs_rise;
    logic go_end;
    logic pix_done;

    assign vs_fall = vsync_q & ~vsync;
    assign vs_rise = ~vsync_q & vsync;

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        r_d           = r_q;
        g_d           = g_q;
        pix_d         = pix_q;
        pix_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_cnt_d    = line_cnt_q;
        first_d       = first_q;
        err_partial_d = err_partial_q;
        err_frame_d   = err_frame_q;
`ifdef PIX_CAPTURE_LINE_CHECK_EN
        pix_cnt_d     = pix_cnt_q;
        err_line_d    = err_line_q;
`endif
        go_end        = 1'b0;
        pix_done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (vs_fall) begin
                    state_d    = S_WAIT_LINE;
                    line_cnt_d = '0;
                    first_d    = 1'b1;
                    byte_idx_d = 2'd0;
`ifdef PIX_CAPTURE_LINE_CHECK_EN
                    pix_cnt_d  = '0;
`endif
                end
            end

            S_WAIT_LINE: begin
                if (vs_rise) begin
                    go_end = 1'b1;
                end else if (href) begin
                    // First byte of a line is consumed on the same cycle href rises.
                    r_d        = byte_in;
                    byte_idx_d = 2'd1;
                    state_d    = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (vs_rise) begin
                    // Aborted line is neither counted nor length-checked.
                    if (byte_idx_q != 2'd0) err_partial_d = 1'b1;
                    byte_idx_d = 2'd0;
                    go_end     = 1'b1;
                end else if (href) begin
                    case (byte_idx_q)
                        2'd0: begin
                            r_d        = byte_in;
                            byte_idx_d = 2'd1;
                        end
                        2'd1: begin
                            g_d        = byte_in;
                            byte_idx_d = 2'd2;
                        end
                        default: begin
                            byte_idx_d = 2'd0;
                            pix_done   = 1'b1;
                        end
                    endcase
                end else begin
                    if (byte_idx_q != 2'd0) err_partial_d = 1'b1;
                    byte_idx_d = 2'd0;
                    if (line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + CNT_WIDTH'(1);
`ifdef PIX_CAPTURE_LINE_CHECK_EN
                    if (pix_cnt_q != CNT_WIDTH'(H_PIXELS)) err_line_d = 1'b1;
                    pix_cnt_d = '0;
`endif
                    if (line_cnt_d == V_LINES_C) go_end = 1'b1;
                    else                         state_d = S_WAIT_LINE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pix_done) begin
`ifdef PIX_CAPTURE_LINE_CHECK_EN
            if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + CNT_WIDTH'(1);
            if (pix_cnt_q < CNT_WIDTH'(H_PIXELS)) begin
`endif
                pix_d       = {r_q, g_q, byte_in};
                pix_valid_d = 1'b1;
                if (first_q) begin
                    frame_start_d = 1'b1;
                    first_d       = 1'b0;
                end
`ifdef PIX_CAPTURE_LINE_CHECK_EN
            end
`endif
        end

        // frame_done and err_frame are registered on entry so both are visible in the END cycle.
        if (go_end) begin
            state_d      = S_END;
            frame_done_d = 1'b1;
            if (line_cnt_d != V_LINES_C) err_frame_d = 1'b1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            vsync_q       <= 1'b0;
            byte_idx_q    <= 2'd0;
            r_q           <= '0;
            g_q           <= '0;
            pix_q         <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_cnt_q    <= '0;
            first_q       <= 1'b0;
            err_partial_q <= 1'b0;
            err_frame_q   <= 1'b0;
`ifdef PIX_CAPTURE_LINE_CHECK_EN
            pix_cnt_q     <= '0;
            err_line_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync;
            byte_idx_q    <= byte_idx_d;
            r_q           <= r_d;
            g_q           <= g_d;
            pix_q         <= pix_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_cnt_q    <= line_cnt_d;
            first_q       <= first_d;
            err_partial_q <= err_partial_d;
            err_frame_q   <= err_frame_d;
`ifdef PIX_CAPTURE_LINE_CHECK_EN
            pix_cnt_q     <= pix_cnt_d;
            err_line_q    <= err_line_d;
`endif
        end
    end

    assign pix_out     = pix_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_cnt    = line_cnt_q;
    assign err_partial = err_partial_q;
    assign err_frame   = err_frame_q;
`ifdef PIX_CAPTURE_LINE_CHECK_EN
    assign err_line    = err_line_q;
`endif

endmodule

// File: tb/tb_pixel_capture.sv
// Directed-vector bench for pixel_capture; pixel p of a frame carries bytes 0x10+p, 0x20+p, 0x30+p.
module tb_pixel_capture;

    localparam int BW = 8;
    localparam int DW = 24;
    localparam int HP = 8;
    localparam int VL = 4;
    localparam int CW = 11;

    logic          wr_clk = 1'b0;
    logic          reset = 1'b1;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [BW-1:0] byte_in = '0;
    logic [DW-1:0] pix_out;
    logic          pix_valid;
    logic          frame_start;
    logic          frame_done;
    logic [CW-1:0] line_cnt;
    logic          err_partial;
    logic          err_frame;
`ifdef PIX_CAPTURE_LINE_CHECK_EN
    logic          err_line;
`endif

    pixel_capture #(
        .BYTE_WIDTH(BW),
        .DATA_WIDTH(DW),
        .H_PIXELS(HP),
        .V_LINES(VL),
        .CNT_WIDTH(CW)
    ) dut (
        .wr_clk(wr_clk),
        .reset(reset),
        .vsync(vsync),
        .href(href),
        .byte_in(byte_in),
        .pix_out(pix_out),
        .pix_valid(pix_valid),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .line_cnt(line_cnt),
        .err_partial(err_partial),
        .err_frame(err_frame)
`ifdef PIX_CAPTURE_LINE_CHECK_EN
        ,
        .err_line(err_line)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int vectors = 0;
    int miscompares = 0;

    // Output monitor, sampled on the falling edge.
    int            cyc = 0;
    int            pv_cnt = 0;
    int            fs_cnt = 0;
    int            fd_cnt = 0;
    int            pv_at_fd = 0;
    logic [DW-1:0] fs_pix = '0;
    logic [DW-1:0] pix_log [512];
    int            pv_cyc [512];

    always @(posedge wr_clk) cyc <= cyc + 1;

    always @(negedge wr_clk) begin
        if (pix_valid) begin
            if (pv_cnt < 512) begin
                pix_log[pv_cnt] = pix_out;
                pv_cyc[pv_cnt]  = cyc;
            end
            pv_cnt++;
            if (frame_start) begin
                fs_cnt++;
                fs_pix = pix_out;
            end
        end
        if (frame_done) begin
            fd_cnt++;
            pv_at_fd = pv_cnt;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] exp_pix(input int p);
        logic [7:0] q;
        q = 8'(p);
        return {8'h10 + q, 8'h20 + q, 8'h30 + q};
    endfunction

    task automatic tick(input logic vs, input logic hr, input logic [BW-1:0] b);
        vsync   = vs;
        href    = hr;
        byte_in = b;
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        reset = 1'b0;
        tick(1'b0, 1'b0, '0);
    endtask

    task automatic frame_fall();
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
    endtask

    task automatic send_bytes(input int first_p, input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            tick(1'b0, 1'b1, 8'(16 * (k % 3 + 1) + first_p + k / 3));
        end
    endtask

    task automatic end_line();
        tick(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        vectors++; if (pix_out !== '0) begin miscompares++; $display("FAIL reset_pix_out: got %h expected 0", pix_out); end
        vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        vectors++; if (line_cnt !== '0) begin miscompares++; $display("FAIL reset_line_cnt: got %0d expected 0", line_cnt); end
        vectors++; if (err_partial !== 1'b0) begin miscompares++; $display("FAIL reset_err_partial: got %b expected 0", err_partial); end
        vectors++; if (err_frame !== 1'b0) begin miscompares++; $display("FAIL reset_err_frame: got %b expected 0", err_frame); end
        reset = 1'b0;
        tick(1'b0, 1'b0, '0);
    endtask

    task automatic clean_frame(input string tag);
        int pv0, fs0, fd0;
        pv0 = pv_cnt; fs0 = fs_cnt; fd0 = fd_cnt;
        frame_fall();
        for (int l = 0; l < VL; l++) begin
            send_bytes(l * HP, 3 * HP);
            end_line();
        end
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL %s_frame_done_pulse: got %b expected 1", tag, frame_done); end
        vectors++; if (line_cnt !== CW'(4)) begin miscompares++; $display("FAIL %s_line_cnt: got %0d expected 4", tag, line_cnt); end
        vectors++; if (err_frame !== 1'b0) begin miscompares++; $display("FAIL %s_err_frame: got %b expected 0", tag, err_frame); end
        vectors++; if (err_partial !== 1'b0) begin miscompares++; $display("FAIL %s_err_partial: got %b expected 0", tag, err_partial); end
`ifdef PIX_CAPTURE_LINE_CHECK_EN
        vectors++; if (err_line !== 1'b0) begin miscompares++; $display("FAIL %s_err_line: got %b expected 0", tag, err_line); end
`endif
        tick(1'b0, 1'b0, '0);
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL %s_frame_done_width: got %b expected 0", tag, frame_done); end
        vectors++; if (pv_cnt - pv0 !== 32) begin miscompares++; $display("FAIL %s_pix_count: got %0d expected 32", tag, pv_cnt - pv0); end
        vectors++; if (fs_cnt - fs0 !== 1) begin miscompares++; $display("FAIL %s_frame_start_count: got %0d expected 1", tag, fs_cnt - fs0); end
        vectors++; if (fs_pix !== 24'h102030) begin miscompares++; $display("FAIL %s_frame_start_pix: got %h expected 102030", tag, fs_pix); end
        vectors++; if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL %s_frame_done_count: got %0d expected 1", tag, fd_cnt - fd0); end
        vectors++; if (pv_at_fd !== pv0 + 32) begin miscompares++; $display("FAIL %s_done_after_last_pix: got %0d expected %0d", tag, pv_at_fd, pv0 + 32); end
        vectors++; if (pv_cyc[pv0 + 1] - pv_cyc[pv0] !== 3) begin miscompares++; $display("FAIL %s_pix_spacing: got %0d expected 3", tag, pv_cyc[pv0 + 1] - pv_cyc[pv0]); end
        for (int p = 0; p < 32; p++) begin
            vectors++;
            if (pix_log[pv0 + p] !== exp_pix(p)) begin
                miscompares++;
                $display("FAIL %s_pix_data[%0d]: got %h expected %h", tag, p, pix_log[pv0 + p], exp_pix(p));
            end
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        clean_frame("full");
    endtask

    task automatic test_partial_line();
        int pv0;
        do_reset();
        pv0 = pv_cnt;
        frame_fall();
        send_bytes(0, 23);
        end_line();
        vectors++; if (pv_cnt - pv0 !== 7) begin miscompares++; $display("FAIL partial_pix_count: got %0d expected 7", pv_cnt - pv0); end
        vectors++; if (pix_log[pv0 + 6] !== exp_pix(6)) begin miscompares++; $display("FAIL partial_last_pix: got %h expected %h", pix_log[pv0 + 6], exp_pix(6)); end
        vectors++; if (err_partial !== 1'b1) begin miscompares++; $display("FAIL partial_err_partial: got %b expected 1", err_partial); end
        vectors++; if (line_cnt !== CW'(1)) begin miscompares++; $display("FAIL partial_line_cnt: got %0d expected 1", line_cnt); end
        tick(1'b1, 1'b0, '0);
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL partial_frame_done: got %b expected 1", frame_done); end
        vectors++; if (err_frame !== 1'b1) begin miscompares++; $display("FAIL partial_err_frame: got %b expected 1", err_frame); end
        tick(1'b1, 1'b0, '0);
    endtask

    task automatic test_vsync_abort();
        int pv0, fd0;
        do_reset();
        pv0 = pv_cnt; fd0 = fd_cnt;
        frame_fall();
        send_bytes(0, 3 * HP);
        end_line();
        send_bytes(HP, 3 * HP);
        end_line();
        send_bytes(2 * HP, 5);
        tick(1'b1, 1'b1, 8'h99);
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL abort_frame_done: got %b expected 1", frame_done); end
        vectors++; if (line_cnt !== CW'(2)) begin miscompares++; $display("FAIL abort_line_cnt: got %0d expected 2", line_cnt); end
        vectors++; if (err_frame !== 1'b1) begin miscompares++; $display("FAIL abort_err_frame: got %b expected 1", err_frame); end
        vectors++; if (err_partial !== 1'b1) begin miscompares++; $display("FAIL abort_err_partial: got %b expected 1", err_partial); end
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        vectors++; if (pv_cnt - pv0 !== 17) begin miscompares++; $display("FAIL abort_pix_count: got %0d expected 17", pv_cnt - pv0); end
        vectors++; if (pix_log[pv0 + 16] !== exp_pix(16)) begin miscompares++; $display("FAIL abort_last_pix: got %h expected %h", pix_log[pv0 + 16], exp_pix(16)); end
        vectors++; if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL abort_frame_done_count: got %0d expected 1", fd_cnt - fd0); end
    endtask

    task automatic test_reset_mid_pixel();
        do_reset();
        frame_fall();
        send_bytes(0, 3 * HP);
        end_line();
        send_bytes(HP, 4);
        reset = 1'b1;
        tick(1'b0, 1'b1, 8'hEE);
        vectors++; if (pix_out !== '0) begin miscompares++; $display("FAIL midrst_pix_out: got %h expected 0", pix_out); end
        vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_pix_valid: got %b expected 0", pix_valid); end
        vectors++; if (line_cnt !== '0) begin miscompares++; $display("FAIL midrst_line_cnt: got %0d expected 0", line_cnt); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL midrst_frame_done: got %b expected 0", frame_done); end
        vectors++; if (err_partial !== 1'b0) begin miscompares++; $display("FAIL midrst_err_partial: got %b expected 0", err_partial); end
        vectors++; if (err_frame !== 1'b0) begin miscompares++; $display("FAIL midrst_err_frame: got %b expected 0", err_frame); end
        tick(1'b0, 1'b0, '0);
        reset = 1'b0;
        tick(1'b0, 1'b0, '0);
        clean_frame("after_rst");
    endtask

    task automatic test_line_length();
        int pv0;
        do_reset();
        pv0 = pv_cnt;
        frame_fall();
        send_bytes(0, 27);
        end_line();
`ifdef PIX_CAPTURE_LINE_CHECK_EN
        vectors++; if (pv_cnt - pv0 !== 8) begin miscompares++; $display("FAIL long_pix_count: got %0d expected 8", pv_cnt - pv0); end
        vectors++; if (err_line !== 1'b1) begin miscompares++; $display("FAIL long_err_line: got %b expected 1", err_line); end
`else
        vectors++; if (pv_cnt - pv0 !== 9) begin miscompares++; $display("FAIL long_pix_count: got %0d expected 9", pv_cnt - pv0); end
        vectors++; if (pix_log[pv0 + 8] !== exp_pix(8)) begin miscompares++; $display("FAIL long_ninth_pix: got %h expected %h", pix_log[pv0 + 8], exp_pix(8)); end
`endif
        vectors++; if (err_partial !== 1'b0) begin miscompares++; $display("FAIL long_err_partial: got %b expected 0", err_partial); end

        do_reset();
        pv0 = pv_cnt;
        frame_fall();
        send_bytes(0, 21);
        end_line();
        vectors++; if (pv_cnt - pv0 !== 7) begin miscompares++; $display("FAIL short_pix_count: got %0d expected 7", pv_cnt - pv0); end
`ifdef PIX_CAPTURE_LINE_CHECK_EN
        vectors++; if (err_line !== 1'b1) begin miscompares++; $display("FAIL short_err_line: got %b expected 1", err_line); end
`endif
        vectors++; if (line_cnt !== CW'(1)) begin miscompares++; $display("FAIL short_line_cnt: got %0d expected 1", line_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_partial_line();
        test_vsync_abort();
        test_reset_mid_pixel();
        test_line_length();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
